// File: rtl/bitcoin_pkg.sv
// Shared types and constants for the nonce search control path.
// Imported by the core scheduler and anything that decodes its state.
package bitcoin_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } sched_state_t;

  localparam logic [31:0] H0_INIT_BEST = 32'hFFFF_FFFF;

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-wins priority encoder: returns the index of the lowest set
// request bit and a valid flag when any request is present.
module prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Hands consecutive nonces to a pool of hash cores and reduces their H0
// results to the minimum value and the nonce that produced it.
module nonce_scheduler
  import bitcoin_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [31:0]            first_nonce,
  input  logic [15:0]            nonce_count,
  output logic [NUM_CORES-1:0]   core_start,
  output logic [31:0]            core_nonce,
  input  logic [NUM_CORES-1:0]   core_done,
  input  logic [NUM_CORES*32-1:0] core_h0,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            best_h0,
  output logic [31:0]            best_nonce
);

  sched_state_t state, state_next;

  logic [31:0] next_nonce;
  logic [15:0] remaining;
  logic [15:0] issued;
  logic [15:0] collected;
  logic [15:0] count_q;
  logic [7:0]  err_cnt;

  logic [NUM_CORES-1:0] core_busy;
  logic [NUM_CORES-1:0] pend;
  logic [31:0]          slot_nonce [NUM_CORES];
  logic [31:0]          slot_h0    [NUM_CORES];

  logic [IDX_W-1:0]     idle_idx;
  logic                 idle_valid;
  logic [IDX_W-1:0]     pend_idx;
  logic                 pend_valid;
  logic [NUM_CORES-1:0] idle_req;
  logic [NUM_CORES-1:0] issue_mask;
  logic [NUM_CORES-1:0] collect_mask;
  logic [NUM_CORES-1:0] capture_mask;
  logic [NUM_CORES-1:0] spurious_mask;
  logic [31:0]          collect_h0;
  logic [31:0]          collect_nonce;

  logic accept;
  logic issue_en;
  logic collect_en;
  logic finish;

  // A slot whose result is still pending may only be reissued in the cycle
  // that result is being collected, so slot_nonce is never overwritten early.
  always_comb begin
    collect_en    = pend_valid && (state != IDLE);
    collect_mask  = collect_en ? (NUM_CORES'(1) << pend_idx) : '0;
    idle_req      = ~core_busy & ~(pend & ~collect_mask);
    issue_mask    = issue_en ? (NUM_CORES'(1) << idle_idx) : '0;
    capture_mask  = core_done & core_busy;
    spurious_mask = core_done & ~core_busy;
    collect_h0    = slot_h0[pend_idx];
    collect_nonce = slot_nonce[pend_idx];
  end

  prio_enc #(
    .N     (NUM_CORES),
    .IDX_W (IDX_W)
  ) u_idle_pick (
    .req   (idle_req),
    .idx   (idle_idx),
    .valid (idle_valid)
  );

  prio_enc #(
    .N     (NUM_CORES),
    .IDX_W (IDX_W)
  ) u_pend_pick (
    .req   (pend),
    .idx   (pend_idx),
    .valid (pend_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (nonce_count == 16'd0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        if ((remaining == 16'd0) || (issue_en && (remaining == 16'd1))) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if ((core_busy == '0) && (pend == '0) && (collected == count_q)) begin
          state_next = FINISH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept   = 1'b0;
    issue_en = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE:    accept   = start;
      ISSUE:   issue_en = (remaining != 16'd0) && idle_valid;
      FINISH:  finish   = 1'b1;
      default: ;
    endcase
  end

  // Run bookkeeping, core issue, result capture/collection and outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      next_nonce <= '0;
      remaining  <= '0;
      issued     <= '0;
      collected  <= '0;
      count_q    <= '0;
      err_cnt    <= '0;
      core_busy  <= '0;
      pend       <= '0;
      core_start <= '0;
      core_nonce <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      best_h0    <= '0;
      best_nonce <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        slot_nonce[i] <= '0;
        slot_h0[i]    <= '0;
      end
    end else begin
      core_start <= '0;
      core_nonce <= '0;
      done       <= 1'b0;

      if (accept) begin
        next_nonce <= first_nonce;
        remaining  <= nonce_count;
        count_q    <= nonce_count;
        issued     <= '0;
        collected  <= '0;
        best_h0    <= H0_INIT_BEST;
        best_nonce <= '0;
        busy       <= 1'b1;
      end

      if (issue_en) begin
        core_start           <= issue_mask;
        core_nonce           <= next_nonce;
        slot_nonce[idle_idx] <= next_nonce;
        next_nonce           <= next_nonce + 32'd1;
        remaining            <= remaining - 16'd1;
        issued               <= issued + 16'd1;
      end

      for (int i = 0; i < NUM_CORES; i++) begin
        if (capture_mask[i]) begin
          slot_h0[i] <= core_h0[32*i +: 32];
        end
      end
      core_busy <= (core_busy & ~capture_mask) | issue_mask;
      pend      <= (pend & ~collect_mask) | capture_mask;

      // Strict compare: on a tie the earlier-collected result stays.
      if (collect_en) begin
        collected <= collected + 16'd1;
        if (collect_h0 < best_h0) begin
          best_h0    <= collect_h0;
          best_nonce <= collect_nonce;
        end
      end

      if (finish) begin
        done <= 1'b1;
        busy <= 1'b0;
      end

      if ((spurious_mask != '0) && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_nonce_scheduler.sv
// Self-checking bench for nonce_scheduler: behavioural hash cores with
// configurable latency and an H0 table, checked against a min-reduction model.
`timescale 1ns/1ps
module tb_nonce_scheduler;

  localparam int NC = 4;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [31:0]       first_nonce;
  logic [15:0]       nonce_count;
  logic [NC-1:0]     core_start;
  logic [31:0]       core_nonce;
  logic [NC-1:0]     core_done;
  logic [NC*32-1:0]  core_h0;
  logic              busy;
  logic              done;
  logic [31:0]       best_h0;
  logic [31:0]       best_nonce;

  int          n_cmp;
  int          n_err;
  int          cyc;
  int          done_pulses;
  logic [31:0] run_first;
  int          run_count;
  logic [31:0] h0_tbl [64];
  int          lat_of [NC];
  bit          rand_lat;
  int          cnt [NC];
  logic [31:0] hval [NC];
  logic [31:0] issued_q [$];
  int          start_cyc_q [$];
  logic [NC-1:0] start_vec_q [$];

  nonce_scheduler #(
    .NUM_CORES (NC),
    .IDX_W     (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .first_nonce (first_nonce),
    .nonce_count (nonce_count),
    .core_start  (core_start),
    .core_nonce  (core_nonce),
    .core_done   (core_done),
    .core_h0     (core_h0),
    .busy        (busy),
    .done        (done),
    .best_h0     (best_h0),
    .best_nonce  (best_nonce)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] h0_for(input logic [31:0] nonce);
    logic [31:0] k;
    k = nonce - run_first;
    if (k < 32'd64) return h0_tbl[k[5:0]];
    return 32'hDEAD_BEEF;
  endfunction

  // Reference: best is the smallest H0 over the range; the first nonce wins ties.
  task automatic expected_best(output logic [31:0] eh, output logic [31:0] en);
    eh = 32'hFFFF_FFFF;
    en = 32'd0;
    for (int k = 0; k < run_count; k++) begin
      if (h0_tbl[k] < eh) begin
        eh = h0_tbl[k];
        en = run_first + 32'(k);
      end
    end
  endtask

  // Behavioural cores: accept a start, return the table H0 after the latency.
  initial begin
    core_done = '0;
    core_h0   = '0;
    for (int i = 0; i < NC; i++) begin
      cnt[i]  = 0;
      hval[i] = '0;
    end
    forever begin
      @(negedge clk);
      core_done = '0;
      for (int i = 0; i < NC; i++) begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            core_done[i]       = 1'b1;
            core_h0[32*i +: 32] = hval[i];
          end
        end
      end
      if (done === 1'b1) done_pulses++;
      if (core_start !== '0) begin
        checkOutput("start_onehot", 32'($onehot(core_start)), 32'd1);
        for (int i = 0; i < NC; i++) begin
          if (core_start[i]) begin
            checkOutput("start_core_idle", 32'(cnt[i] == 0 && !core_done[i]), 32'd1);
            issued_q.push_back(core_nonce);
            start_cyc_q.push_back(cyc);
            start_vec_q.push_back(core_start);
            hval[i] = h0_for(core_nonce);
            cnt[i]  = rand_lat ? int'($urandom_range(2, 9)) : lat_of[i];
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] first, input logic [15:0] count);
    run_first   = first;
    run_count   = int'(count);
    issued_q.delete();
    start_cyc_q.delete();
    start_vec_q.delete();
    done_pulses = 0;
    first_nonce = first;
    nonce_count = count;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("accept_busy", 32'(busy), 32'd1);
    checkOutput("accept_no_start", 32'(core_start), 32'd0);
    checkOutput("accept_no_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    if (count != 16'd0) begin
      checkOutput("first_core_start", 32'(core_start), 32'd1);
      checkOutput("first_core_nonce", core_nonce, first);
    end else begin
      checkOutput("empty_done", 32'(done), 32'd1);
      checkOutput("empty_busy", 32'(busy), 32'd0);
      checkOutput("empty_no_start", 32'(core_start), 32'd0);
    end
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n;
    logic [31:0] eh;
    logic [31:0] en;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, "_done_seen"}, 32'(done), 32'd1);
    checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    expected_best(eh, en);
    checkOutput({tag, "_best_h0"}, best_h0, eh);
    checkOutput({tag, "_best_nonce"}, best_nonce, en);
    checkOutput({tag, "_issue_count"}, 32'(issued_q.size()), 32'(run_count));
    for (int k = 0; k < issued_q.size() && k < run_count; k++) begin
      checkOutput({tag, "_issued_nonce"}, issued_q[k], run_first + 32'(k));
    end
    @(posedge clk); #1;
    checkOutput({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    checkOutput({tag, "_done_pulses"}, 32'(done_pulses), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_core_start"}, 32'(core_start), 32'd0);
    checkOutput({tag, "_core_nonce"}, core_nonce, 32'd0);
    checkOutput({tag, "_best_h0"}, best_h0, 32'd0);
    checkOutput({tag, "_best_nonce"}, best_nonce, 32'd0);
  endtask

  initial begin
    int n;
    int exp_seq [4];
    logic [31:0] r;

    n_cmp       = 0;
    n_err       = 0;
    done_pulses = 0;
    run_first   = '0;
    run_count   = 0;
    rand_lat    = 1'b0;
    reset_n     = 1'b0;
    start       = 1'b0;
    first_nonce = '0;
    nonce_count = '0;
    for (int i = 0; i < NC; i++) lat_of[i] = 10;
    for (int k = 0; k < 64; k++) h0_tbl[k] = 32'hFFFF_FFFF;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] run 1: four nonces, tie on H0=30");
    h0_tbl[0] = 32'd40; h0_tbl[1] = 32'd30; h0_tbl[2] = 32'd50; h0_tbl[3] = 32'd30;
    applyStimulus(32'd0, 16'd4);
    waitDone("t1", 200);
    for (int k = 0; k < start_vec_q.size() && k < 4; k++) begin
      checkOutput("t1_start_vec", 32'(start_vec_q[k]), 32'd1 << k);
      checkOutput("t1_start_consecutive", 32'(start_cyc_q[k] - start_cyc_q[0]), 32'(k));
    end

    $display("[TB] run 2: ten nonces, latency 5");
    for (int i = 0; i < NC; i++) lat_of[i] = 5;
    for (int k = 0; k < 10; k++) begin
      r = $urandom();
      h0_tbl[k] = {r[31:16], 16'(k)};
    end
    applyStimulus(32'd0, 16'd10);
    waitDone("t2", 300);

    $display("[TB] run 3: all cores finish in the same cycle");
    lat_of[0] = 10; lat_of[1] = 9; lat_of[2] = 8; lat_of[3] = 7;
    h0_tbl[0] = 32'd9; h0_tbl[1] = 32'd7; h0_tbl[2] = 32'd8; h0_tbl[3] = 32'd6;
    exp_seq[0] = 9; exp_seq[1] = 7; exp_seq[2] = 7; exp_seq[3] = 6;
    applyStimulus(32'd100, 16'd4);
    n = 0;
    while (core_done !== 4'hF && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("t3_all_done_together", 32'(core_done), 32'hF);
    checkOutput("t3_best_before_collect", best_h0, 32'hFFFF_FFFF);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checkOutput("t3_collect_order", best_h0, 32'(exp_seq[k]));
    end
    waitDone("t3", 100);

    $display("[TB] run 4: nonce wrap");
    for (int i = 0; i < NC; i++) lat_of[i] = 10;
    h0_tbl[0] = 32'h0000_0500; h0_tbl[1] = 32'h0000_0300; h0_tbl[2] = 32'h0000_0200;
    applyStimulus(32'hFFFF_FFFE, 16'd3);
    waitDone("t4", 200);

    $display("[TB] run 5: empty range");
    applyStimulus(32'h1234_5678, 16'd0);
    checkOutput("t5_best_h0", best_h0, 32'hFFFF_FFFF);
    checkOutput("t5_best_nonce", best_nonce, 32'd0);
    @(posedge clk); #1;
    checkOutput("t5_done_one_cycle", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t5_no_issue", 32'(issued_q.size()), 32'd0);

    $display("[TB] runs 6-8: random ranges and latencies");
    rand_lat = 1'b1;
    for (int t = 0; t < 3; t++) begin
      r = $urandom();
      n = int'($urandom_range(5, 40));
      for (int k = 0; k < 64; k++) begin
        logic [31:0] rv;
        rv = $urandom();
        h0_tbl[k] = {rv[31:16], 16'(k)};
      end
      applyStimulus(r, 16'(n));
      waitDone("rand", 800);
    end
    rand_lat = 1'b0;

    $display("[TB] run 9: reset mid-drain, then rerun");
    lat_of[0] = 4; lat_of[1] = 4; lat_of[2] = 30; lat_of[3] = 30;
    h0_tbl[0] = 32'd1000; h0_tbl[1] = 32'd900; h0_tbl[2] = 32'd1; h0_tbl[3] = 32'd2;
    applyStimulus(32'h0000_0500, 16'd4);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t9_busy_mid_drain", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t9_in_reset");
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("t9_held_reset");
    reset_n = 1'b1;
    for (int i = 0; i < NC; i++) lat_of[i] = 12;
    h0_tbl[0] = 32'd500; h0_tbl[1] = 32'd400;
    applyStimulus(32'h0000_0020, 16'd2);
    waitDone("t9", 200);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("t9_best_held", best_h0, 32'd400);
    checkOutput("t9_nonce_held", best_nonce, 32'h0000_0021);
    checkOutput("t9_stale_no_done", 32'(done_pulses), 32'd1);
    checkOutput("t9_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
